// File: rtl/qbert_jump_ctrl.sv
// qbert_jump_ctrl
//   Turns direction requests into jump commands for the Q*bert sprite layer,
//   tracks Q*bert's cube on the 28-cube pyramid, keeps the visited-cube map
//   and flags bad jumps (leaving the pyramid) and the winning jump.
//
// Ports
//   clk, reset           clock, asynchronous active-low reset
//   req_dir, req_valid   direction request (001 DR, 010 DL, 011 UR, 100 UL)
//   req_ready            request accepted when req_valid && req_ready
//   e_start_qb           restart pulse (highest priority)
//   e_pause_qb           blocks acceptance of new requests
//   done_move, state_qb  handshake from the animation layer (010 = IDLE)
//   e_jump_qb            last jump direction (sprite orientation)
//   position_qb          one-hot current cube, bit0 = top
//   e_next_qb            one-hot target cube, zero when leaving the pyramid
//   e_bad_jump           current jump leaves the pyramid
//   e_win_qb             current jump completes the pyramid
//   visited              cubes already landed on
//   timeout_err          sticky layer-handshake timeout, cleared by e_start_qb
module qbert_jump_ctrl #(
   parameter logic [31:0] TIMEOUT = 32'd50_000_000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [2:0]  req_dir,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        e_start_qb,
   input  logic        e_pause_qb,
   input  logic        done_move,
   input  logic [2:0]  state_qb,
   output logic [2:0]  e_jump_qb,
   output logic [27:0] position_qb,
   output logic [27:0] e_next_qb,
   output logic        e_bad_jump,
   output logic        e_win_qb,
   output logic [27:0] visited,
   output logic        timeout_err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT_LO,
      S_WAIT_HI,
      S_COMMIT,
      S_DONE
   } state_t;

   localparam logic [2:0]  QB_IDLE   = 3'b010;
   localparam logic [27:0] ALL_CUBES = 28'hFFF_FFFF;

   state_t      state;
   logic [2:0]  row, col;
   logic [2:0]  t_row, t_col;
   logic        bad_r;
   logic [31:0] cnt;

   logic [2:0]  n_row, n_col;
   logic        n_bad, n_valid;
   logic [27:0] n_oh;

   // Cube (r, c) sits at bit r(r-1)/2 + c; 6-bit math keeps 7*6 from overflowing.
   function automatic logic [27:0] cube_oh(input logic [2:0] r, input logic [2:0] c);
      logic [5:0] r6;
      logic [5:0] idx;
      r6      = {3'b000, r};
      idx     = ((r6 * (r6 - 6'd1)) >> 1) + {3'b000, c};
      cube_oh = 28'd1 << idx;
   endfunction

   always_comb begin
      n_row   = row;
      n_col   = col;
      n_bad   = 1'b0;
      n_valid = 1'b1;
      case (req_dir)
         3'b001: begin
            n_row = row + 3'd1;
            n_bad = (row == 3'd7);
         end
         3'b010: begin
            n_row = row + 3'd1;
            n_col = col + 3'd1;
            n_bad = (row == 3'd7);
         end
         3'b011: begin
            n_row = row - 3'd1;
            n_col = col - 3'd1;
            n_bad = (row == 3'd1) || (col == 3'd0);
         end
         3'b100: begin
            n_row = row - 3'd1;
            n_bad = (row == 3'd1) || (col == row - 3'd1);
         end
         default: n_valid = 1'b0;
      endcase
   end

   assign n_oh        = cube_oh(n_row, n_col);
   assign position_qb = cube_oh(row, col);

   // Gated by reset so the handshake stays low while reset is held.
   assign req_ready = reset && (state == S_IDLE) && !e_pause_qb && done_move &&
                      (state_qb == QB_IDLE);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= S_IDLE;
         row         <= 3'd1;
         col         <= 3'd0;
         t_row       <= 3'd1;
         t_col       <= 3'd0;
         bad_r       <= 1'b0;
         cnt         <= '0;
         e_jump_qb   <= '0;
         e_next_qb   <= 28'h1;
         visited     <= 28'h1;
         e_bad_jump  <= 1'b0;
         e_win_qb    <= 1'b0;
         timeout_err <= 1'b0;
      end else if (e_start_qb) begin
         state       <= S_IDLE;
         row         <= 3'd1;
         col         <= 3'd0;
         t_row       <= 3'd1;
         t_col       <= 3'd0;
         bad_r       <= 1'b0;
         cnt         <= '0;
         e_jump_qb   <= '0;
         e_next_qb   <= 28'h1;
         visited     <= 28'h1;
         e_bad_jump  <= 1'b0;
         e_win_qb    <= 1'b0;
         timeout_err <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               // Unknown direction codes are consumed without any effect.
               if (req_valid && req_ready && n_valid) begin
                  t_row      <= n_row;
                  t_col      <= n_col;
                  bad_r      <= n_bad;
                  e_next_qb  <= n_bad ? '0 : n_oh;
                  e_jump_qb  <= req_dir;
                  e_bad_jump <= n_bad;
                  e_win_qb   <= !n_bad && ((visited | n_oh) == ALL_CUBES);
                  cnt        <= '0;
                  state      <= S_WAIT_LO;
               end
            end
            S_WAIT_LO, S_WAIT_HI: begin
               if ((TIMEOUT != 32'd0) && (cnt == TIMEOUT)) begin
                  // Abandon the jump: the layer sees e_next == position and stays put.
                  timeout_err <= 1'b1;
                  e_next_qb   <= position_qb;
                  e_bad_jump  <= 1'b0;
                  e_win_qb    <= 1'b0;
                  cnt         <= '0;
                  state       <= S_IDLE;
               end else if ((state == S_WAIT_LO) && !done_move) begin
                  cnt   <= '0;
                  state <= S_WAIT_HI;
               end else if ((state == S_WAIT_HI) && done_move &&
                            ((state_qb == QB_IDLE) || e_win_qb)) begin
                  cnt   <= '0;
                  state <= S_COMMIT;
               end else begin
                  cnt <= cnt + 32'd1;
               end
            end
            S_COMMIT: begin
               if (!bad_r) begin
                  row       <= t_row;
                  col       <= t_col;
                  visited   <= visited | cube_oh(t_row, t_col);
                  e_next_qb <= cube_oh(t_row, t_col);
               end else begin
                  row       <= 3'd1;
                  col       <= 3'd0;
                  e_next_qb <= 28'h1;
               end
               e_bad_jump <= 1'b0;
               state      <= e_win_qb ? S_DONE : S_IDLE;
            end
            S_DONE: state <= S_DONE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_qbert_jump_ctrl.sv
// Scoreboard bench for qbert_jump_ctrl: the stimulus side predicts each jump
// from pyramid geometry and queues the expectation; a monitor pops it when the
// DUT accepts a request and compares launch and landing outputs. A small
// animation-layer model answers the done_move/state_qb handshake.
module tb_qbert_jump_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [2:0]  req_dir;
   logic        req_valid;
   logic        req_ready;
   logic        e_start_qb;
   logic        e_pause_qb;
   logic        done_move;
   logic [2:0]  state_qb;
   logic [2:0]  e_jump_qb;
   logic [27:0] position_qb;
   logic [27:0] e_next_qb;
   logic        e_bad_jump;
   logic        e_win_qb;
   logic [27:0] visited;
   logic        timeout_err;

   qbert_jump_ctrl #(.TIMEOUT(32'd100)) dut (
      .clk         (clk),
      .reset       (reset),
      .req_dir     (req_dir),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .e_start_qb  (e_start_qb),
      .e_pause_qb  (e_pause_qb),
      .done_move   (done_move),
      .state_qb    (state_qb),
      .e_jump_qb   (e_jump_qb),
      .position_qb (position_qb),
      .e_next_qb   (e_next_qb),
      .e_bad_jump  (e_bad_jump),
      .e_win_qb    (e_win_qb),
      .visited     (visited),
      .timeout_err (timeout_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        drop;
      logic        tmo_case;
      logic [27:0] l_next;
      logic        l_bad;
      logic        l_win;
      logic [2:0]  l_jump;
      logic [27:0] c_pos;
      logic [27:0] c_vis;
      logic        c_win;
      logic        c_tmo;
   } item_t;

   item_t sb_q[$];
   int    checks   = 0;
   int    failures = 0;
   int    phase    = 0;
   logic  layer_stuck = 1'b0;

   // Reference model: position as (row, col), visited as a set of cube bits.
   int          mr = 1;
   int          mc = 0;
   logic [27:0] mvis  = 28'h1;
   logic [2:0]  mjump = 3'd0;
   logic        mtmo  = 1'b0;
   logic        mwin  = 1'b0;

   function automatic logic [27:0] oh(input int r, input int c);
      logic [27:0] v;
      v = '0;
      v[r * (r - 1) / 2 + c] = 1'b1;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [27:0] act, input logic [27:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   task automatic build(input logic [2:0] dir, input logic stuck, output item_t it);
      int   tr, tc;
      logic bad, all;
      tr = mr;
      tc = mc;
      it.drop = 1'b0;
      it.tmo_case = stuck;
      case (dir)
         3'd1: tr = mr + 1;
         3'd2: begin tr = mr + 1; tc = mc + 1; end
         3'd3: begin tr = mr - 1; tc = mc - 1; end
         3'd4: tr = mr - 1;
         default: it.drop = 1'b1;
      endcase
      if (it.drop) begin
         it.tmo_case = 1'b0;
         it.l_next = oh(mr, mc);
         it.l_bad  = 1'b0;
         it.l_win  = mwin;
         it.l_jump = mjump;
         it.c_pos  = oh(mr, mc);
         it.c_vis  = mvis;
         it.c_win  = mwin;
         it.c_tmo  = mtmo;
         return;
      end
      bad = !(tr >= 1 && tr <= 7 && tc >= 0 && tc < tr);
      if (bad) begin
         all = 1'b0;
         it.l_next = '0;
      end else begin
         all = ((mvis | oh(tr, tc)) == 28'hFFF_FFFF);
         it.l_next = oh(tr, tc);
      end
      it.l_bad  = bad;
      it.l_win  = all;
      it.l_jump = dir;
      mjump = dir;
      if (stuck) begin
         mtmo = 1'b1;
         it.c_win = 1'b0;
      end else begin
         if (bad) begin
            mr = 1;
            mc = 0;
         end else begin
            mr = tr;
            mc = tc;
            mvis = mvis | oh(tr, tc);
         end
         mwin = all;
         it.c_win = all;
      end
      it.c_pos = oh(mr, mc);
      it.c_vis = mvis;
      it.c_tmo = mtmo;
   endtask

   // Monitor: pop on accept, check launch one cycle later, check landing when
   // e_next_qb settles back onto position_qb.
   initial begin
      item_t cur;
      int    wait_n;
      logic  exp_rdy;
      wait_n = 0;
      forever begin
         @(negedge clk);
         if (phase == 1) begin
            chk("launch_next", e_next_qb, cur.l_next);
            chk("launch_bad", e_bad_jump, cur.l_bad);
            chk("launch_win", e_win_qb, cur.l_win);
            chk("launch_jump", e_jump_qb, cur.l_jump);
            phase  = cur.drop ? 0 : 2;
            wait_n = 0;
         end else if (phase == 2) begin
            wait_n++;
            if (e_next_qb == position_qb) begin
               exp_rdy = !cur.c_win && !e_pause_qb && done_move && (state_qb == 3'b010);
               chk("land_pos", position_qb, cur.c_pos);
               chk("land_visited", visited, cur.c_vis);
               chk("land_win", e_win_qb, cur.c_win);
               chk("land_bad", e_bad_jump, 1'b0);
               chk("land_tmo", timeout_err, cur.c_tmo);
               chk("land_ready", req_ready, exp_rdy);
               if (cur.tmo_case)
                  chk("tmo_latency", (wait_n >= 99 && wait_n <= 103), 1'b1);
               phase = 0;
            end else if (wait_n > 1000) begin
               chk("land_wait", e_next_qb, cur.c_pos);
               phase = 0;
            end
         end
         if (phase == 0 && reset && req_valid && req_ready) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_accept", req_valid, 1'b0);
            end else begin
               cur   = sb_q.pop_front();
               phase = 1;
            end
         end
      end
   end

   // Animation-layer model.
   initial begin
      logic lbad, lwin;
      done_move = 1'b1;
      state_qb  = 3'b010;
      forever begin
         @(negedge clk);
         if (reset && !layer_stuck && (e_next_qb != position_qb)) begin
            lbad = e_bad_jump;
            lwin = e_win_qb;
            repeat ($urandom_range(1, 4)) @(posedge clk);
            #1 done_move = 1'b0; state_qb = 3'b001;
            repeat ($urandom_range(1, 12)) @(posedge clk);
            #1 done_move = 1'b1;
            if (lwin) begin
               state_qb = 3'b101;
               for (int i = 0; i < 3000; i++) begin
                  @(posedge clk);
                  if (e_start_qb) break;
               end
               #1 state_qb = 3'b010;
            end else if (lbad) begin
               state_qb = 3'b100;
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1 state_qb = 3'b011;
               repeat ($urandom_range(1, 3)) @(posedge clk);
               #1 state_qb = 3'b010;
            end else begin
               state_qb = 3'b010;
            end
         end
      end
   end

   task automatic issue(input logic [2:0] dir, input logic stuck, input logic pz);
      item_t it;
      int    n;
      build(dir, stuck, it);
      sb_q.push_back(it);
      @(posedge clk);
      #1 req_dir = dir; req_valid = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         #1;
         if (req_ready || n > 200) break;
         n++;
      end
      chk("accept_wait", req_ready, 1'b1);
      if (!req_ready) begin
         sb_q.delete();
         req_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1 req_valid = 1'b0;
      if (pz) e_pause_qb = 1'b1;
      n = 0;
      forever begin
         @(negedge clk);
         #2;
         if ((sb_q.size() == 0 && phase == 0) || n > 2000) break;
         n++;
      end
      chk("item_wait", (sb_q.size() == 0 && phase == 0), 1'b1);
      e_pause_qb = 1'b0;
   endtask

   task automatic do_start();
      @(posedge clk);
      #1 e_start_qb = 1'b1;
      @(posedge clk);
      #1 e_start_qb = 1'b0;
      @(negedge clk);
      chk("start_pos", position_qb, 28'h1);
      chk("start_next", e_next_qb, 28'h1);
      chk("start_visited", visited, 28'h1);
      chk("start_win", e_win_qb, 1'b0);
      chk("start_bad", e_bad_jump, 1'b0);
      chk("start_tmo", timeout_err, 1'b0);
      chk("start_jump", e_jump_qb, 3'd0);
      mr = 1; mc = 0; mvis = 28'h1; mjump = 3'd0; mtmo = 1'b0; mwin = 1'b0;
      repeat (2) @(posedge clk);
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

   initial begin
      int walk[30] = '{1,1,1,1,1,1, 4, 2, 4,4,4,4,4, 2, 1,1,1,1, 4, 2, 4,4,4, 2, 1,1, 4, 2, 4, 2};
      int n_rdy;
      logic [2:0] d;
      reset = 1'b0; req_dir = 3'd0; req_valid = 1'b0;
      e_start_qb = 1'b0; e_pause_qb = 1'b0;
      @(negedge clk);
      chk("reset_pos", position_qb, 28'h1);
      chk("reset_next", e_next_qb, 28'h1);
      chk("reset_visited", visited, 28'h1);
      chk("reset_jump", e_jump_qb, 3'd0);
      chk("reset_flags", {e_bad_jump, e_win_qb, timeout_err}, 3'b000);
      chk("reset_ready", req_ready, 1'b0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      repeat (2) @(posedge clk);

      issue(3'd1, 1'b0, 1'b0);                         // DOWN_RIGHT from top
      do_start();
      issue(3'd2, 1'b0, 1'b0);
      issue(3'd2, 1'b0, 1'b0);
      issue(3'd4, 1'b0, 1'b0);
      chk("dl_dl_ul_visited", visited, 28'h25);
      do_start();
      issue(3'd3, 1'b0, 1'b0);                         // off the pyramid
      issue(3'd0, 1'b0, 1'b0);                         // dropped code
      issue(3'd6, 1'b0, 1'b0);

      layer_stuck = 1'b1;                              // layer never answers
      issue(3'd1, 1'b1, 1'b0);
      layer_stuck = 1'b0;
      do_start();

      @(posedge clk);
      #1 e_pause_qb = 1'b1; req_dir = 3'd1; req_valid = 1'b1;
      n_rdy = 0;
      repeat (10) begin
         @(negedge clk);
         if (req_ready) n_rdy++;
      end
      chk("pause_ready", n_rdy, 0);
      chk("pause_nojump", e_next_qb, oh(mr, mc));
      @(posedge clk);
      #1 req_valid = 1'b0; e_pause_qb = 1'b0;
      issue(3'd2, 1'b0, 1'b1);                         // pause raised mid-jump

      for (int i = 0; i < 120; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            d = 3'($urandom_range(5, 8));
            if (d == 3'd0 || d >= 3'd5) issue(d, 1'b0, 1'b0);
         end else begin
            issue(3'($urandom_range(1, 4)), 1'b0, 1'($urandom_range(0, 1)));
         end
         if (mwin || $urandom_range(0, 19) == 0) do_start();
      end

      do_start();
      for (int i = 0; i < 30; i++) issue(3'(walk[i]), 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      chk("done_ready", req_ready, 1'b0);
      chk("done_win", e_win_qb, 1'b1);
      chk("done_visited", visited, 28'hFFF_FFFF);
      chk("done_pos", position_qb, 28'h800_0000);
      do_start();

      repeat (5) @(posedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
